// File: rtl/wrapper_package.sv
// Shared types for the SPI RAM master: command and FSM encodings, frame size, frame builder.
// Optional build macro SPI_MASTER_RR_ARB_EN is consumed by spi_ram_arbiter only.
package wrapper_package;

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEL_LOW,
        SHIFT,
        RD_WAIT,
        RD_SHIFT,
        GAP,
        RESP
    } master_state_e;

    // Frame word as sent MSB first: sel (a copy of cmd[1]), cmd[1:0], payload[7:0].
    function automatic logic [FRAME_BITS-1:0] build_frame(input spi_cmd_e cmd,
                                                          input logic [7:0] payload);
        logic [1:0] c;
        c = cmd;
        return {c[1], c, payload};
    endfunction

endpackage

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter: combinational grant, registered last-granted pointer.
// SPI_MASTER_RR_ARB_EN selects round-robin ties; otherwise requester 0 always wins.
module spi_ram_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       take,
    output logic       gnt_any,
    output logic       gnt_id,
    output logic       last_id
);

    assign gnt_any = |req_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_id = 1'b0;
`ifdef SPI_MASTER_RR_ARB_EN
        if (&req_valid)
            gnt_id = ~last_id;
        else
            gnt_id = req_valid[1];
`else
        if (!req_valid[0])
            gnt_id = 1'b1;
`endif
    end

    // Resetting to 1 makes requester 0 the winner of the first round-robin tie.
    always_ff @(posedge clk) begin
        if (rst)
            last_id <= 1'b1;
        else if (take)
            last_id <= gnt_id;
    end

endmodule

// File: rtl/spi_ram_master.sv
// Two-port SPI RAM master: arbitrates requests and expands each into an address frame
// plus a data frame on SS_n/MOSI, capturing read data from MISO. Macro: SPI_MASTER_RR_ARB_EN.
module spi_ram_master
    import wrapper_package::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MISO_DLY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_rw,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [7:0]          rsp_rdata,
    output logic                busy,
    output logic                SS_n,
    output logic                MOSI,
    input  logic                MISO
);

    localparam int WAIT_W = (MISO_DLY > 1) ? $clog2(MISO_DLY) : 1;

    master_state_e           state;
    spi_cmd_e                cur_cmd;
    logic [FRAME_BITS-1:0]   frame;
    logic [3:0]              bit_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    second;
    logic                    op_rw;
    logic [ADDR_W-1:0]       op_addr;
    logic [7:0]              op_wdata;
    logic [7:0]              rx;
    logic                    take;
    logic                    gnt_any;
    logic                    gnt_id;
    logic                    last_id;

    assign take = (state == IDLE) && gnt_any;

    spi_ram_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .take      (take),
        .gnt_any   (gnt_any),
        .gnt_id    (gnt_id),
        .last_id   (last_id)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= 8'h00;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cur_cmd   <= WR_ADDR;
            frame     <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            second    <= 1'b0;
            op_rw     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            rx        <= '0;
        end else begin
            req_ready <= 2'b00;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        req_ready <= gnt_id ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        op_rw     <= req_rw[gnt_id];
                        op_addr   <= req_addr[gnt_id*ADDR_W +: ADDR_W];
                        op_wdata  <= req_wdata[gnt_id*8 +: 8];
                        state     <= GRANT;
                    end
                end

                GRANT: begin
                    cur_cmd <= op_rw ? RD_ADDR : WR_ADDR;
                    frame   <= build_frame(op_rw ? RD_ADDR : WR_ADDR, op_addr);
                    SS_n    <= 1'b0;
                    MOSI    <= op_rw;
                    bit_cnt <= 4'd10;
                    second  <= 1'b0;
                    state   <= SEL_LOW;
                end

                // The check cycle already drives sel (bit 10); SHIFT walks bits 9..0.
                SEL_LOW, SHIFT: begin
                    if (bit_cnt == 4'd0) begin
                        MOSI <= 1'b0;
                        if (cur_cmd == RD_DATA) begin
                            if (MISO_DLY == 0) begin
                                bit_cnt <= 4'd7;
                                state   <= RD_SHIFT;
                            end else begin
                                wait_cnt <= WAIT_W'(MISO_DLY - 1);
                                state    <= RD_WAIT;
                            end
                        end else begin
                            SS_n  <= 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        MOSI    <= frame[bit_cnt - 4'd1];
                        bit_cnt <= bit_cnt - 4'd1;
                        state   <= SHIFT;
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        bit_cnt <= 4'd7;
                        state   <= RD_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                RD_SHIFT: begin
                    rx <= {rx[6:0], MISO};
                    if (bit_cnt == 4'd0) begin
                        SS_n  <= 1'b1;
                        state <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end

                GAP: begin
                    if (!second) begin
                        second  <= 1'b1;
                        cur_cmd <= op_rw ? RD_DATA : WR_DATA;
                        frame   <= build_frame(op_rw ? RD_DATA : WR_DATA,
                                               op_rw ? 8'h00 : op_wdata);
                        SS_n    <= 1'b0;
                        MOSI    <= op_rw;
                        bit_cnt <= 4'd10;
                        state   <= SEL_LOW;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= last_id;
                        rsp_rdata <= op_rw ? rx : 8'h00;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
